uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 40 ++++
 rtl/uart_tx_arbiter.sv | 145 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_pkg : shared FSM state encoding and header sync nibble for UART TX muxing
// Rev 1.0
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_DATA   = 2'd2
  } tx_state_e;

  localparam logic [3:0] HDR_SYNC = 4'hA;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_arbiter : combinational round-robin pick, search begins just after ptr
// Rev 1.0
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NumReq = 4,
  parameter int IdxW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req,
  input  logic [IdxW-1:0]   ptr,
  output logic [NumReq-1:0] grant,
  output logic [IdxW-1:0]   idx
);

  logic found;

  // Two passes: indices above ptr first, then wrap around to 0..ptr.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int j = 0; j < NumReq; j++) begin
      if (!found && (j > int'(ptr)) && req[j]) begin
        grant[j] = 1'b1;
        idx      = IdxW'(j);
        found    = 1'b1;
      end
    end
    for (int j = 0; j < NumReq; j++) begin
      if (!found && (j <= int'(ptr)) && req[j]) begin
        grant[j] = 1'b1;
        idx      = IdxW'(j);
        found    = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_tx_arbiter : round-robin sharing of one UART TX FIFO among requesters
// Rev 1.0
// ---------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NumReq     = 4,
  parameter int DataLength = 8,
  parameter bit HeaderEn   = 1'b1,
  parameter int MaxMsgLen  = 16
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [NumReq-1:0]            i_req_valid,
  input  logic [NumReq*DataLength-1:0] i_req_data,
  input  logic [NumReq-1:0]            i_req_last,
  output logic [NumReq-1:0]            o_req_ready,
  output logic [DataLength-1:0]        o_tx_data,
  output logic                         o_tx_req,
  input  logic                         i_tx_rdy,
  output logic [NumReq-1:0]            o_grant,
  output logic                         o_busy,
  output logic                         o_trunc
);

  localparam int         IdxW    = $clog2(NumReq);
  localparam logic [7:0] LAST_CNT = 8'(MaxMsgLen - 1);

  tx_state_e             state, state_nxt;
  logic [NumReq-1:0]     grant;
  logic [IdxW-1:0]       owner;
  logic [IdxW-1:0]       ptr;
  logic [7:0]            byte_cnt;

  logic [NumReq-1:0]     arb_grant;
  logic [IdxW-1:0]       arb_idx;
  logic                  sel_valid;
  logic                  sel_last;
  logic [DataLength-1:0] sel_data;
  logic [DataLength-1:0] hdr_byte;
  logic                  xfer;
  logic                  msg_done;
  logic                  start;

  rr_arbiter #(
    .NumReq (NumReq),
    .IdxW   (IdxW)
  ) u_rr (
    .req   (i_req_valid),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  // Owner mux driven by the registered one-hot grant.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int k = 0; k < NumReq; k++) begin
      if (grant[k]) begin
        sel_valid = i_req_valid[k];
        sel_last  = i_req_last[k];
        sel_data  = i_req_data[k*DataLength +: DataLength];
      end
    end
  end

  always_comb begin
    hdr_byte                   = '0;
    hdr_byte[DataLength-1 -: 4] = HDR_SYNC;
    hdr_byte[IdxW-1:0]         = owner;
  end

  assign start = (state == ST_IDLE) && (|i_req_valid);

  always_comb begin
    state_nxt   = state;
    o_tx_req    = 1'b0;
    o_tx_data   = '0;
    o_req_ready = '0;
    o_trunc     = 1'b0;
    xfer        = 1'b0;
    msg_done    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = HeaderEn ? ST_HEADER : ST_DATA;
      end
      ST_HEADER: begin
        o_tx_req = i_tx_rdy;
        if (i_tx_rdy) begin
          o_tx_data = hdr_byte;
          state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        o_req_ready = grant & {NumReq{i_tx_rdy}};
        xfer        = sel_valid & i_tx_rdy;
        o_tx_req    = xfer;
        if (xfer) begin
          o_tx_data = sel_data;
          if (sel_last) begin
            msg_done  = 1'b1;
            state_nxt = ST_IDLE;
          end else if (byte_cnt == LAST_CNT) begin
            // Remaining bytes of this requester re-arbitrate as a new message.
            o_trunc   = 1'b1;
            msg_done  = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= ST_IDLE;
      grant    <= '0;
      owner    <= '0;
      ptr      <= IdxW'(NumReq - 1);
      byte_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        grant    <= arb_grant;
        owner    <= arb_idx;
        byte_cnt <= '0;
      end
      if (xfer) byte_cnt <= byte_cnt + 8'd1;
      if (msg_done) begin
        grant <= '0;
        ptr   <= owner;
      end
    end
  end

  assign o_grant = grant;
  assign o_busy  = (state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter : scoreboard bench, requester byte queues feed the DUT
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [N-1:0]    req_valid, req_last, req_ready, grant;
  logic [N*DW-1:0] req_data;
  logic [DW-1:0]   tx_data;
  logic            tx_req, tx_rdy, busy, trunc;

  logic [N-1:0]    nh_valid, nh_last, nh_ready, nh_grant;
  logic [N*DW-1:0] nh_data;
  logic [DW-1:0]   nh_tx_data;
  logic            nh_tx_req, nh_rdy, nh_busy, nh_trunc;

  uart_tx_arbiter #(.NumReq(N), .DataLength(DW), .HeaderEn(1'b1), .MaxMsgLen(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_data(req_data),
    .i_req_last(req_last), .o_req_ready(req_ready), .o_tx_data(tx_data),
    .o_tx_req(tx_req), .i_tx_rdy(tx_rdy), .o_grant(grant), .o_busy(busy),
    .o_trunc(trunc)
  );

  uart_tx_arbiter #(.NumReq(N), .DataLength(DW), .HeaderEn(1'b0), .MaxMsgLen(16)) dut_nh (
    .i_clk(clk), .i_rst(rst), .i_req_valid(nh_valid), .i_req_data(nh_data),
    .i_req_last(nh_last), .o_req_ready(nh_ready), .o_tx_data(nh_tx_data),
    .o_tx_req(nh_tx_req), .i_tx_rdy(nh_rdy), .o_grant(nh_grant), .o_busy(nh_busy),
    .o_trunc(nh_trunc)
  );

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mon_exp;
  logic [DW:0]   rbuf [N][64];
  int            rhead[N];
  int            rtail[N];
  logic [N-1:0]  acc;

  // Requester model: present queue head, advance on an accepted handshake.
  always begin
    @(negedge clk);
    acc = req_ready & req_valid;
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      if (acc[k] && (rhead[k] < rtail[k])) rhead[k]++;
      if (rhead[k] < rtail[k]) begin
        req_valid[k]         = 1'b1;
        req_data[k*DW +: DW] = rbuf[k][rhead[k]][DW-1:0];
        req_last[k]          = rbuf[k][rhead[k]][DW];
      end else begin
        req_valid[k]         = 1'b0;
        req_data[k*DW +: DW] = '0;
        req_last[k]          = 1'b0;
      end
    end
  end

  // FIFO-side scoreboard.
  always @(negedge clk) begin
    n_checks++;
    if (tx_req) begin
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL tx_write: got 0x%02h, expected no write", tx_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (tx_data !== mon_exp) begin
          n_fail++;
          $display("FAIL tx_write: got 0x%02h, expected 0x%02h", tx_data, mon_exp);
        end
      end
    end else if (tx_data !== '0) begin
      n_fail++;
      $display("FAIL tx_data_idle: got 0x%02h, expected 0x00", tx_data);
    end
  end

  task automatic wait_idle(input int budget);
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) break;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    n_checks++; if (grant !== '0)   begin n_fail++; $display("FAIL reset_grant: got %b, expected 0000", grant); end
    n_checks++; if (tx_req !== 1'b0) begin n_fail++; $display("FAIL reset_tx_req: got %b, expected 0", tx_req); end
    n_checks++; if (req_ready !== '0) begin n_fail++; $display("FAIL reset_ready: got %b, expected 0000", req_ready); end
    n_checks++; if (trunc !== 1'b0) begin n_fail++; $display("FAIL reset_trunc: got %b, expected 0", trunc); end
    n_checks++; if (nh_busy !== 1'b0) begin n_fail++; $display("FAIL reset_nh_busy: got %b, expected 0", nh_busy); end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_single();
    rbuf[2][rtail[2]] = {1'b0, 8'h11}; rtail[2]++;
    rbuf[2][rtail[2]] = {1'b0, 8'h22}; rtail[2]++;
    rbuf[2][rtail[2]] = {1'b1, 8'h33}; rtail[2]++;
    exp_q.push_back(8'hA2); exp_q.push_back(8'h11);
    exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    for (int c = 0; c < 20 && !tx_req; c++) @(negedge clk);
    n_checks++;
    if (tx_req !== 1'b1) begin n_fail++; $display("FAIL single_start: got tx_req %b, expected 1 within 20 cycles", tx_req); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (tx_req !== 1'b1 || grant !== 4'b0100) begin
        n_fail++;
        $display("FAIL single_burst[%0d]: got tx_req %b grant %b, expected 1 and 0100", i, tx_req, grant);
      end
      @(negedge clk);
    end
    n_checks++;
    if (busy !== 1'b0 || grant !== '0) begin
      n_fail++; $display("FAIL single_end: got busy %b grant %b, expected 0 and 0000", busy, grant);
    end
    wait_idle(50);
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL single_drain: got %0d pending, expected 0", exp_q.size()); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] prev;
    bit           was_idle;
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < N; k++) begin
        rbuf[k][rtail[k]] = {1'b1, 8'(8'h10 * (r + 1) + k)}; rtail[k]++;
      end
    end
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < N; k++) begin
        exp_q.push_back(8'(8'hA0 + k));
        exp_q.push_back(8'(8'h10 * (r + 1) + k));
      end
    end
    prev     = '0;
    was_idle = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (grant != '0 && was_idle) begin
        n_checks++;
        if (grant === prev) begin n_fail++; $display("FAIL rr_repeat: got grant %b twice, expected a different requester", grant); end
        prev     = grant;
        was_idle = 1'b0;
      end
      if (grant == '0) was_idle = 1'b1;
      if (exp_q.size() == 0 && !busy) break;
    end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL rr_drain: got %0d pending, expected 0", exp_q.size()); end
  endtask

  task automatic test_trunc();
    int  pulses;
    bit  chk_idle;
    for (int i = 0; i < 20; i++) begin
      rbuf[0][rtail[0]] = {(i == 19), 8'(8'h40 + i)}; rtail[0]++;
    end
    exp_q.push_back(8'hA0);
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(8'h40 + i));
    exp_q.push_back(8'hA0);
    for (int i = 16; i < 20; i++) exp_q.push_back(8'(8'h40 + i));
    pulses   = 0;
    chk_idle = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (chk_idle) begin
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL trunc_idle: got busy %b, expected 0", busy); end
        chk_idle = 1'b0;
      end
      if (trunc === 1'b1) begin
        pulses++;
        n_checks++;
        if (tx_req !== 1'b1 || tx_data !== 8'h4F) begin
          n_fail++; $display("FAIL trunc_byte: got tx_req %b data 0x%02h, expected 1 and 0x4f", tx_req, tx_data);
        end
        chk_idle = 1'b1;
      end
      if (exp_q.size() == 0 && !busy) break;
    end
    n_checks++;
    if (pulses != 1) begin n_fail++; $display("FAIL trunc_pulses: got %0d, expected 1", pulses); end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL trunc_drain: got %0d pending, expected 0", exp_q.size()); end
  endtask

  task automatic test_stall();
    logic [3:0] pat;
    pat = 4'b1001;
    rbuf[1][rtail[1]] = {1'b0, 8'h61}; rtail[1]++;
    rbuf[1][rtail[1]] = {1'b0, 8'h62}; rtail[1]++;
    rbuf[1][rtail[1]] = {1'b1, 8'h63}; rtail[1]++;
    exp_q.push_back(8'hA1); exp_q.push_back(8'h61);
    exp_q.push_back(8'h62); exp_q.push_back(8'h63);
    for (int c = 0; c < 20 && !tx_req; c++) @(negedge clk);
    n_checks++;
    if (tx_req !== 1'b1) begin n_fail++; $display("FAIL stall_start: got tx_req %b, expected 1 within 20 cycles", tx_req); end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1 tx_rdy = pat[3-i];
      @(negedge clk);
      n_checks++;
      if (tx_req !== pat[3-i] || grant !== 4'b0010) begin
        n_fail++; $display("FAIL stall_cycle[%0d]: got tx_req %b grant %b, expected %b and 0010", i, tx_req, grant, pat[3-i]);
      end
      if (i > 0) begin
        n_checks++;
        if (dut.byte_cnt !== 8'd1) begin n_fail++; $display("FAIL stall_count[%0d]: got %0d, expected 1", i, dut.byte_cnt); end
      end
      if (!pat[3-i]) begin
        n_checks++;
        if (req_ready !== '0 || busy !== 1'b1) begin
          n_fail++; $display("FAIL stall_hold[%0d]: got ready %b busy %b, expected 0000 and 1", i, req_ready, busy);
        end
      end
    end
    wait_idle(50);
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL stall_drain: got %0d pending, expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    int writes;
    for (int i = 0; i < 5; i++) begin
      rbuf[3][rtail[3]] = {(i == 4), 8'(8'h71 + i)}; rtail[3]++;
    end
    exp_q.push_back(8'hA3); exp_q.push_back(8'h71); exp_q.push_back(8'h72);
    writes = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (tx_req) writes++;
      if (writes == 3) break;
    end
    n_checks++;
    if (writes != 3) begin n_fail++; $display("FAIL rstmid_writes: got %0d, expected 3", writes); end
    #1 rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (tx_req !== 1'b0 || grant !== '0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_abandon: got tx_req %b grant %b busy %b, expected 0 0000 0", tx_req, grant, busy);
    end
    rhead[3] = 0; rtail[3] = 0;
    @(posedge clk); #1 rst = 1'b0;
    rbuf[0][rtail[0]] = {1'b1, 8'h81}; rtail[0]++;
    rbuf[3][rtail[3]] = {1'b1, 8'h91}; rtail[3]++;
    exp_q.push_back(8'hA0); exp_q.push_back(8'h81);
    exp_q.push_back(8'hA3); exp_q.push_back(8'h91);
    for (int c = 0; c < 20 && grant == '0; c++) @(negedge clk);
    n_checks++;
    if (grant !== 4'b0001) begin n_fail++; $display("FAIL rstmid_first_grant: got %b, expected 0001", grant); end
    wait_idle(50);
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL rstmid_drain: got %0d pending, expected 0", exp_q.size()); end
  endtask

  task automatic test_no_header();
    int writes;
    @(posedge clk); #1;
    nh_valid[1]      = 1'b1;
    nh_data[DW +: DW] = 8'h55;
    nh_last[1]       = 1'b1;
    writes = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (nh_tx_req) begin
        writes++;
        n_checks++;
        if (nh_tx_data !== 8'h55 || nh_grant !== 4'b0010 || nh_ready !== 4'b0010) begin
          n_fail++; $display("FAIL nohdr_byte: got data 0x%02h grant %b ready %b, expected 0x55 0010 0010", nh_tx_data, nh_grant, nh_ready);
        end
      end
      @(posedge clk); #1;
      if (writes > 0) begin nh_valid = '0; nh_last = '0; nh_data = '0; end
    end
    n_checks++;
    if (writes != 1) begin n_fail++; $display("FAIL nohdr_writes: got %0d, expected 1", writes); end
    n_checks++;
    if (nh_busy !== 1'b0) begin n_fail++; $display("FAIL nohdr_idle: got busy %b, expected 0", nh_busy); end
  endtask

  initial begin
    rst       = 1'b1;
    tx_rdy    = 1'b1;
    req_valid = '0; req_last = '0; req_data = '0;
    nh_valid  = '0; nh_last  = '0; nh_data  = '0; nh_rdy = 1'b1;
    for (int k = 0; k < N; k++) begin rhead[k] = 0; rtail[k] = 0; end
    test_reset();
    test_single();
    test_round_robin();
    test_trunc();
    test_stall();
    test_reset_mid();
    test_no_header();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
